// File: rtl/mole_pkg.sv
// mole_pkg: built-in trigger table and DIY table geometry shared by mole and mole_table.
package mole_pkg;

  localparam int ADDR_W        = 23;
  localparam int LOC_W         = 4;
  localparam int IDX_W         = 4;
  localparam int BUILTIN_LEN   = 8;
  localparam int BUILTIN_IDX_W = $clog2(BUILTIN_LEN);
  localparam int DIY_SLOTS     = 5;
  localparam int DIY_ADDR_W    = 24;
  localparam int DIY_LOC_W     = 4;

  // Element 0 is the earliest trigger, so it sits rightmost in the concatenation.
  localparam logic [BUILTIN_LEN-1:0][ADDR_W-1:0] BUILTIN_ADDR = {
    23'h013FC0, 23'h0121A0, 23'h010380, 23'h00E560,
    23'h00C740, 23'h00A920, 23'h008B01, 23'h006CDF
  };

  localparam logic [BUILTIN_LEN-1:0][LOC_W-1:0] BUILTIN_LOC = {
    4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0
  };

endpackage

// File: rtl/mole_table.sv
// mole_table: returns the trigger address/location at idx for the active table.
// The DIY table is only built when MOLE_DIY_EN is defined.
module mole_table
  import mole_pkg::*;
(
  input  logic [IDX_W-1:0]                idx_i,
  input  logic                            using_diy_i,
  input  logic [DIY_SLOTS*DIY_ADDR_W-1:0] diy_addresses_i,
  input  logic [DIY_SLOTS*DIY_LOC_W-1:0]  diy_locations_i,
  output logic [ADDR_W-1:0]               entry_addr_o,
  output logic [LOC_W-1:0]                entry_loc_o,
  output logic                            entry_live_o,
  output logic [IDX_W-1:0]                table_len_o
);

`ifdef MOLE_DIY_EN
  logic [ADDR_W-1:0]    slot_addr [DIY_SLOTS];
  logic [LOC_W-1:0]     slot_loc  [DIY_SLOTS];
  logic [DIY_SLOTS-1:0] slot_msb;
  logic                 unused_slot_msb;

  genvar gi;
  generate
    for (gi = 0; gi < DIY_SLOTS; gi++) begin : g_slot
      assign slot_addr[gi] = diy_addresses_i[gi*DIY_ADDR_W +: ADDR_W];
      assign slot_msb[gi]  = diy_addresses_i[gi*DIY_ADDR_W + ADDR_W];
      assign slot_loc[gi]  = diy_locations_i[gi*DIY_LOC_W +: LOC_W];
    end
  endgenerate

  // Top bit of each 24-bit slot carries no address information.
  assign unused_slot_msb = ^slot_msb;
`else
  logic unused_diy;
  assign unused_diy = ^{using_diy_i, diy_addresses_i, diy_locations_i};
`endif

  always_comb begin
    entry_addr_o = '0;
    entry_loc_o  = '0;
    entry_live_o = 1'b1;
    table_len_o  = IDX_W'(BUILTIN_LEN);
    if (idx_i < IDX_W'(BUILTIN_LEN)) begin
      entry_addr_o = BUILTIN_ADDR[idx_i[BUILTIN_IDX_W-1:0]];
      entry_loc_o  = BUILTIN_LOC[idx_i[BUILTIN_IDX_W-1:0]];
    end
`ifdef MOLE_DIY_EN
    if (using_diy_i) begin
      table_len_o  = IDX_W'(DIY_SLOTS);
      entry_addr_o = '0;
      entry_loc_o  = '0;
      for (int s = 0; s < DIY_SLOTS; s++) begin
        if (idx_i == IDX_W'(s)) begin
          entry_addr_o = slot_addr[s];
          entry_loc_o  = slot_loc[s];
        end
      end
      // A zero address marks an unused slot: it is stepped over silently.
      entry_live_o = (entry_addr_o != '0);
    end
`endif
  end

endmodule

// File: rtl/mole.sv
// mole: emits one request_mole pulse per trigger-table entry crossed by the song address.
// Optional DIY trigger table enabled by defining MOLE_DIY_EN.
module mole
  import mole_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_W-1:0]               music_address,
  input  logic                            using_diy,
  input  logic [DIY_SLOTS*DIY_ADDR_W-1:0] diy_addresses,
  input  logic [DIY_SLOTS*DIY_LOC_W-1:0]  diy_locations,
  output logic                            request_mole,
  output logic [LOC_W-1:0]                mole_location
);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic              request_q, request_d;
  logic [LOC_W-1:0]  location_q, location_d;
  logic              restart;

  logic [ADDR_W-1:0] entry_addr;
  logic [LOC_W-1:0]  entry_loc;
  logic              entry_live;
  logic [IDX_W-1:0]  table_len;

  mole_table u_table (
    .idx_i           (idx_q),
    .using_diy_i     (using_diy),
    .diy_addresses_i (diy_addresses),
    .diy_locations_i (diy_locations),
    .entry_addr_o    (entry_addr),
    .entry_loc_o     (entry_loc),
    .entry_live_o    (entry_live),
    .table_len_o     (table_len)
  );

`ifdef MOLE_DIY_EN
  logic mode_q;

  always_ff @(posedge clk) begin
    if (reset) mode_q <= 1'b0;
    else       mode_q <= using_diy;
  end

  // Switching tables rewinds exactly like a song restart.
  assign restart = (music_address < last_addr_q) || (using_diy != mode_q);
`else
  assign restart = (music_address < last_addr_q);
`endif

  always_comb begin
    idx_d      = idx_q;
    request_d  = 1'b0;
    location_d = location_q;
    if (restart) begin
      idx_d = '0;
    end else if ((idx_q < table_len) && (music_address >= entry_addr)) begin
      idx_d = idx_q + 1'b1;
      if (entry_live) begin
        request_d  = 1'b1;
        location_d = entry_loc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      last_addr_q <= '0;
      request_q   <= 1'b0;
      location_q  <= '0;
    end else begin
      idx_q       <= idx_d;
      last_addr_q <= music_address;
      request_q   <= request_d;
      location_q  <= location_d;
    end
  end

  assign request_mole  = request_q;
  assign mole_location = location_q;

endmodule

// File: tb/tb_mole.sv
// tb_mole: directed and randomized checks of mole against a behavioural trigger model.
module tb_mole;

  logic         clk = 1'b0;
  logic         reset;
  logic [22:0]  music_address;
  logic         using_diy;
  logic [119:0] diy_addresses;
  logic [19:0]  diy_locations;
  logic         request_mole;
  logic [3:0]   mole_location;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mole dut (
    .clk           (clk),
    .reset         (reset),
    .music_address (music_address),
    .using_diy     (using_diy),
    .diy_addresses (diy_addresses),
    .diy_locations (diy_locations),
    .request_mole  (request_mole),
    .mole_location (mole_location)
  );

  always #5 clk = ~clk;

  // Reference model: pointer into the active trigger list, one step per clock.
  int bi_addr [8] = '{'h6CDF, 'h8B01, 'hA920, 'hC740, 'hE560, 'h10380, 'h121A0, 'h13FC0};
  int m_idx = 0;
  int m_last = 0;
  bit m_mode = 1'b0;
  bit exp_req = 1'b0;
  int exp_loc = 0;

  always @(posedge clk) begin : model
    int len;
    int ea;
    int el;
    bit diy;
    bit rst;
    if (reset) begin
      m_idx = 0; m_last = 0; m_mode = 1'b0; exp_req = 1'b0; exp_loc = 0;
    end else begin
      diy = 1'b0;
`ifdef MOLE_DIY_EN
      diy = using_diy;
`endif
      rst = (int'(music_address) < m_last) || (diy != m_mode);
      exp_req = 1'b0;
      len = diy ? 5 : 8;
      if (rst) begin
        m_idx = 0;
      end else if (m_idx < len) begin
        if (diy) begin
          ea = int'(diy_addresses[24*m_idx +: 23]);
          el = int'(diy_locations[4*m_idx +: 4]);
        end else begin
          ea = bi_addr[m_idx];
          el = m_idx;
        end
        if (int'(music_address) >= ea) begin
          m_idx = m_idx + 1;
          if (ea != 0) begin
            exp_req = 1'b1;
            exp_loc = el;
          end
        end
      end
      m_last = int'(music_address);
      m_mode = diy;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (request_mole !== exp_req) begin
        errors++;
        $display("FAIL model_req t=%0t addr=%h: got %b want %b", $time, music_address, request_mole, exp_req);
      end
      checks++;
      if (mole_location !== exp_loc[3:0]) begin
        errors++;
        $display("FAIL model_loc t=%0t addr=%h: got %0d want %0d", $time, music_address, mole_location, exp_loc);
      end
    end
  end

  task automatic step(input logic [22:0] a, input bit rst);
    @(negedge clk);
    music_address = a;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input bit r, input int l);
    checks++;
    if (request_mole !== r || mole_location !== l[3:0]) begin
      errors++;
      $display("FAIL %s: got req=%b loc=%0d want req=%b loc=%0d", name, request_mole, mole_location, r, l);
    end else begin
      $display("ok   %s: req=%b loc=%0d", name, request_mole, mole_location);
    end
  endtask

  initial begin
    logic [22:0] addr;
    int pulses;
    int first_pulse;
    int acc;
    reset = 1'b1;
    music_address = '0;
    using_diy = 1'b0;
    diy_addresses = '0;
    diy_locations = '0;

    step(23'h0, 1'b1);
    cmp_en = 1'b1;
    step(23'h0, 1'b1);
    expect_lit("reset_state", 1'b0, 0);

    // First two triggers, one address per cycle.
    step(23'h0, 1'b0);      expect_lit("seq_0",      1'b0, 0);
    step(23'h6CDE, 1'b0);   expect_lit("seq_6CDE",   1'b0, 0);
    step(23'h6CDF, 1'b0);   expect_lit("seq_6CDF",   1'b1, 0);
    step(23'h8B00, 1'b0);   expect_lit("seq_8B00",   1'b0, 0);
    step(23'h8B01, 1'b0);   expect_lit("seq_8B01",   1'b1, 1);
    // Restart on address drop.
    step(23'h0, 1'b0);      expect_lit("drop_nopulse", 1'b0, 1);
    step(23'h6CDF, 1'b0);   expect_lit("after_drop",   1'b1, 0);
    step(23'h6CDF, 1'b0);   expect_lit("after_drop_hold", 1'b0, 0);

    // Held address gives one pulse.
    step(23'h0, 1'b1);
    step(23'h0, 1'b0);
    pulses = 0; first_pulse = -1;
    for (int i = 0; i < 10; i++) begin
      step(23'h6CDF, 1'b0);
      if (request_mole === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    checks++;
    if (pulses != 1 || first_pulse != 0) begin
      errors++;
      $display("FAIL hold_single: got %0d pulses (first at %0d) want 1 (first at 0)", pulses, first_pulse);
    end else $display("ok   hold_single: 1 pulse");

    // Jump across three triggers.
    step(23'h0, 1'b1);
    step(23'h0, 1'b0);
    step(23'hA920, 1'b0);   expect_lit("jump_p0", 1'b1, 0);
    step(23'hA920, 1'b0);   expect_lit("jump_p1", 1'b1, 1);
    step(23'hA920, 1'b0);   expect_lit("jump_p2", 1'b1, 2);
    step(23'hA920, 1'b0);   expect_lit("jump_end", 1'b0, 2);

    // Reset overrides a match in the same cycle.
    step(23'h6CDF, 1'b1);   expect_lit("reset_vs_match", 1'b0, 0);
    step(23'h6CDF, 1'b0);   expect_lit("post_reset_idx0", 1'b1, 0);

    // Run off the end of the table.
    for (int i = 1; i < 8; i++) begin
      step(23'h7FFFFF, 1'b0);
      expect_lit($sformatf("tail_%0d", i), 1'b1, i);
    end
    step(23'h7FFFFF, 1'b0); expect_lit("table_done",   1'b0, 7);
    step(23'h7FFFFF, 1'b0); expect_lit("table_done_2", 1'b0, 7);

`ifdef MOLE_DIY_EN
    step(23'h0, 1'b1);
    diy_addresses = '0;
    diy_addresses[23:0] = 24'h800100;
    diy_locations = '0;
    diy_locations[3:0] = 4'd5;
    using_diy = 1'b1;
    step(23'h0, 1'b0);      expect_lit("diy_modechg", 1'b0, 0);
    step(23'h80, 1'b0);     expect_lit("diy_below",   1'b0, 0);
    step(23'h100, 1'b0);    expect_lit("diy_slot0",   1'b1, 5);
    for (int i = 0; i < 6; i++) begin
      step(23'h100, 1'b0);
      expect_lit($sformatf("diy_skip_%0d", i), 1'b0, 5);
    end
    using_diy = 1'b0;
    step(23'h100, 1'b0);    expect_lit("diy_back_restart", 1'b0, 5);
    step(23'h6CDF, 1'b0);   expect_lit("diy_back_builtin", 1'b1, 0);
`endif

    // Randomized run.
    step(23'h0, 1'b1);
    addr = '0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 80)      addr = addr + 23'($urandom_range(0, 'h1800));
      else if (r < 88) addr = addr + 23'($urandom_range(0, 'h30000));
      else if (r < 94) addr = 23'($urandom_range(0, int'(addr)));
      else if (r < 97) addr = 23'h0;
`ifdef MOLE_DIY_EN
      if ($urandom_range(0, 49) == 0) using_diy = ~using_diy;
      if ($urandom_range(0, 199) == 0) begin
        acc = 0;
        for (int s = 0; s < 5; s++) begin
          if ($urandom_range(0, 2) == 0) begin
            diy_addresses[24*s +: 24] = {1'($urandom), 23'h0};
          end else begin
            acc = acc + int'($urandom_range(1, 'h8000));
            diy_addresses[24*s +: 24] = {1'($urandom), 23'(acc)};
          end
          diy_locations[4*s +: 4] = 4'($urandom);
        end
      end
`endif
      step(addr, ($urandom_range(0, 149) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
